// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: debounce FSM states and default timing constants shared by the shift-stage front end
package shiftreg_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int TICK_DIV_DEF = 5000000;
    typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} db_state_t;
endpackage

// File: rtl/btn_sync2.sv
// btn_sync2: two-flop synchronizer for an asynchronous level
module btn_sync2 (
    input  logic clkin,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clkin) begin
        if (!rstn) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronize and debounce a push-button, emit edge pulses and a periodic step tick
module button_conditioner
    import shiftreg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clkin,
    input  logic rstn,
    input  logic button,
    output logic button_level,
    output logic button_rise,
    output logic button_fall,
    output logic step_tick
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
    logic sync;
    db_state_t state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [TW-1:0] tcnt;
    logic level_n, rise_n, fall_n;
    btn_sync2 u_sync (
        .clkin(clkin),
        .rstn(rstn),
        .d(button),
        .q(sync)
    );
    always_comb begin
        state_n = state;
        dcnt_n = dcnt;
        level_n = button_level;
        rise_n = 1'b0;
        fall_n = 1'b0;
        case (state)
            S_LOW: if (sync) begin
                state_n = S_RISE_CHK;
                dcnt_n = '0;
            end
            S_RISE_CHK: if (!sync) state_n = S_LOW;
            else if (dcnt == DMAX) begin
                state_n = S_HIGH;
                level_n = 1'b1;
                rise_n = 1'b1;
            end else dcnt_n = dcnt + 1'b1;
            S_HIGH: if (!sync) begin
                state_n = S_FALL_CHK;
                dcnt_n = '0;
            end
            S_FALL_CHK: if (sync) state_n = S_HIGH;
            else if (dcnt == DMAX) begin
                state_n = S_LOW;
                level_n = 1'b0;
                fall_n = 1'b1;
            end else dcnt_n = dcnt + 1'b1;
        endcase
    end
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state <= S_LOW;
            dcnt <= '0;
            button_level <= 1'b0;
            button_rise <= 1'b0;
            button_fall <= 1'b0;
        end else begin
            state <= state_n;
            dcnt <= dcnt_n;
            button_level <= level_n;
            button_rise <= rise_n;
            button_fall <= fall_n;
        end
    end
    // tick registers on the wrap edge so it lands on the TICK_DIV-th edge after reset
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            tcnt <= '0;
            step_tick <= 1'b0;
        end else begin
            tcnt <= (tcnt == TMAX) ? '0 : tcnt + 1'b1;
            step_tick <= (tcnt == TMAX);
        end
    end
endmodule
